game_tick_sequencer: RTL and testbench
======================================

Name: game_tick_sequencer

Overview:
Game-level controller for the Dino design. Runs in the device_clock domain and consumes the divided clk_20Hz (game tick) and clk_500Hz (button scan) outputs of the clock divider as sampled data signals. Owns the game state machine (IDLE/RUN/OVER). On each game tick it issues an ordered series of one-cycle update strobes to the obstacle, dino and collision datapaths, then updates score and speed level.

Parameters:
SPEED_STEP_TICKS, 200, successful game ticks per speed_level increment
MAX_LEVEL, 7, saturation value of speed_level (must fit in 3 bits)
SCORE_W, 16, score width
LOCKOUT_TICKS, 10, game ticks after entering OVER during which presses are ignored

Ports:
device_clock  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
clk_20Hz  in  1  divided game tick from the clock divider, treated as async data
clk_500Hz  in  1  divided button-scan clock from the clock divider, treated as async data
btn_jump  in  1  debounced jump button, level, 1 = pressed
collision  in  1  collision result, valid in the cycle after chk_collide
game_state  out  2  00 IDLE, 01 RUN, 10 OVER
upd_obstacle  out  1  one-cycle strobe: advance obstacles
upd_dino  out  1  one-cycle strobe: advance dino physics
chk_collide  out  1  one-cycle strobe: evaluate collision
jump_req  out  1  pending jump, sticky until consumed
speed_level  out  3  current speed level
score  out  SCORE_W  ticks survived

Behaviour:
- Reset (rst=0, async): game_state=IDLE; all strobes 0; jump_req 0; speed_level 0; score 0; synchronizers, edge detectors, sequencer and counters cleared. Reset mid-sequence aborts with no partial strobes after release.
- clk_20Hz and clk_500Hz each pass through a 2-flop synchronizer and a rising-edge detector, giving tick20 and tick500 one-cycle pulses. Each pulse appears 3 cycles after the input rising edge.
- btn_jump is sampled only on tick500. press = 1-cycle pulse when the sample is 1 and the previous sample was 0. A held button yields exactly one press.
- FSM:
  - IDLE: press -> RUN. score, speed_level, step counter and jump_req all cleared. The starting press does not set jump_req.
  - RUN: press sets jump_req. On tick20 with the sequencer idle, the sequencer runs:
    - cycle T: upd_obstacle=1
    - T+1: upd_dino=1, jump_req cleared in the same edge
    - T+2: chk_collide=1
    - T+3: collision sampled. If 1: -> OVER, score and level frozen, lockout counter = 0. If 0: score+1 (saturates at all-ones), step counter +1. When the step counter reaches SPEED_STEP_TICKS-1 it wraps to 0 and speed_level increments, saturating at MAX_LEVEL.
  - OVER: no strobes. Each tick20 increments the lockout counter, saturating at LOCKOUT_TICKS. A press with lockout < LOCKOUT_TICKS is ignored. A press once the lockout is reached -> RUN with the same clearing as from IDLE.
- Exactly one strobe is high in any cycle; strobes are never high outside RUN.
- A tick20 arriving while the sequencer is busy is dropped, not queued.
- A press in the same cycle as upd_dino leaves jump_req=1; the new press wins over the clear.
- collision is ignored except at T+3.
- All outputs are registered.

Test Plan:
1. Reset: hold rst=0 with random inputs -> all outputs 0, game_state=00. Release, no inputs for 100 cycles -> unchanged.
2. Start and sequence: press in IDLE -> game_state=01, jump_req=0. Drive a clk_20Hz edge -> upd_obstacle, upd_dino, chk_collide on 3 consecutive cycles starting 3 cycles after the edge; with collision=0, score=1 one cycle after chk_collide.
3. Jump: press in RUN -> jump_req=1. Next tick -> jump_req=0 after the upd_dino edge. Press timed to land on the upd_dino cycle -> jump_req stays 1.
4. Speed: SPEED_STEP_TICKS=4, MAX_LEVEL=2, 12 collision-free ticks -> speed_level 1 after tick 4, 2 after tick 8, still 2 after tick 12; score=12.
5. Game over and lockout: collision=1 at T+3 -> game_state=10, score frozen, no further strobes. Press after 3 ticks -> stays OVER. Press after 10 ticks -> RUN with score=0, speed_level=0.
6. Held button and reset mid-sequence: btn_jump held for 50 tick500 periods -> a single press. Assert rst at T+1 -> no chk_collide after release, all outputs 0.

Source files
------------

// File: rtl/game_tick_sequencer_if.sv
// game_tick_sequencer_if: strobe/status bundle between the game sequencer and its datapaths
// Ports: game_state, upd_obstacle, upd_dino, chk_collide, jump_req, speed_level, score from the sequencer;
//        collision back from the collision datapath.
interface game_tick_sequencer_if #(parameter int SCORE_W = 16);
    logic [1:0]         game_state;
    logic               upd_obstacle;
    logic               upd_dino;
    logic               chk_collide;
    logic               collision;
    logic               jump_req;
    logic [2:0]         speed_level;
    logic [SCORE_W-1:0] score;
    modport master (output game_state, upd_obstacle, upd_dino, chk_collide, jump_req, speed_level, score,
                    input collision);
    modport slave  (input game_state, upd_obstacle, upd_dino, chk_collide, jump_req, speed_level, score,
                    output collision);
endinterface

// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer: Dino game FSM issuing ordered per-tick update strobes, score and speed level
// Ports: device_clock, rst (async active-low), clk_20Hz/clk_500Hz (async divided clocks sampled as data),
//        btn_jump (debounced level), bus (master side of game_tick_sequencer_if).
module game_tick_sequencer #(
    parameter int SPEED_STEP_TICKS = 200,
    parameter int MAX_LEVEL        = 7,
    parameter int SCORE_W          = 16,
    parameter int LOCKOUT_TICKS    = 10
) (
    input  logic                   device_clock,
    input  logic                   rst,
    input  logic                   clk_20Hz,
    input  logic                   clk_500Hz,
    input  logic                   btn_jump,
    game_tick_sequencer_if.master  bus
);
    localparam int STEP_W = SPEED_STEP_TICKS > 1 ? $clog2(SPEED_STEP_TICKS) : 1;
    localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_STEP_TICKS - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCKOUT_TICKS);
    localparam logic [2:0]        LEVEL_MAX = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

    state_t             state_q, state_d;
    logic [2:0]         s20_q, s500_q;
    logic               btn_prev_q;
    logic               obs_q, obs_d, dino_q, dino_d, chk_q, chk_d, smp_q, smp_d;
    logic               jump_q, jump_d;
    logic [2:0]         level_q, level_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic               tick20, tick500, press, busy, start;

    // bit 0/1 synchronize, bit 2 holds the previous synchronized level for edge detection
    assign tick20  = s20_q[1] & ~s20_q[2];
    assign tick500 = s500_q[1] & ~s500_q[2];
    assign press   = tick500 & btn_jump & ~btn_prev_q;
    // smp_q marks T+3, the cycle in which collision is valid
    assign busy    = obs_q | dino_q | chk_q | smp_q;
    assign start   = press & (state_q == IDLE || (state_q == OVER && lock_q == LOCK_MAX));

    always_ff @(posedge device_clock or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s20_q      <= '0;
            s500_q     <= '0;
            btn_prev_q <= 1'b0;
            obs_q      <= 1'b0;
            dino_q     <= 1'b0;
            chk_q      <= 1'b0;
            smp_q      <= 1'b0;
            jump_q     <= 1'b0;
            level_q    <= '0;
            score_q    <= '0;
            step_q     <= '0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            s20_q      <= {s20_q[1:0], clk_20Hz};
            s500_q     <= {s500_q[1:0], clk_500Hz};
            btn_prev_q <= tick500 ? btn_jump : btn_prev_q;
            obs_q      <= obs_d;
            dino_q     <= dino_d;
            chk_q      <= chk_d;
            smp_q      <= smp_d;
            jump_q     <= jump_d;
            level_q    <= level_d;
            score_q    <= score_d;
            step_q     <= step_d;
            lock_q     <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        obs_d   = 1'b0;
        dino_d  = 1'b0;
        chk_d   = 1'b0;
        smp_d   = 1'b0;
        jump_d  = jump_q;
        level_d = level_q;
        score_d = score_q;
        step_d  = step_q;
        lock_d  = lock_q;
        if (start) begin
            state_d = RUN;
            jump_d  = 1'b0;
            level_d = '0;
            score_d = '0;
            step_d  = '0;
        end else if (state_q == OVER) begin
            lock_d = (tick20 && lock_q != LOCK_MAX) ? lock_q + LOCK_W'(1) : lock_q;
        end else if (state_q == RUN) begin
            obs_d  = tick20 & ~busy;
            dino_d = obs_q;
            chk_d  = dino_q;
            smp_d  = chk_q;
            // the dino datapath consumes jump_req during upd_dino; a press in that same cycle survives
            jump_d = press | (jump_q & ~dino_q);
            if (smp_q && bus.collision) begin
                state_d = OVER;
                lock_d  = '0;
            end else if (smp_q) begin
                score_d = &score_q ? score_q : score_q + SCORE_W'(1);
                step_d  = step_q == STEP_LAST ? '0 : step_q + STEP_W'(1);
                level_d = (step_q == STEP_LAST && level_q != LEVEL_MAX) ? level_q + 3'd1 : level_q;
            end
        end
    end

    assign bus.game_state   = state_q;
    assign bus.upd_obstacle = obs_q;
    assign bus.upd_dino     = dino_q;
    assign bus.chk_collide  = chk_q;
    assign bus.jump_req     = jump_q;
    assign bus.speed_level  = level_q;
    assign bus.score        = score_q;
endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb_game_tick_sequencer: directed and randomized checks of game_tick_sequencer against a rule-level model
module tb_game_tick_sequencer;
    localparam int STEP = 4;
    localparam int MAXL = 2;
    localparam int LOCK = 10;

    logic device_clock = 1'b0;
    logic rst = 1'b0;
    logic clk_20Hz = 1'b0;
    logic clk_500Hz = 1'b0;
    logic btn_jump = 1'b0;

    game_tick_sequencer_if #(.SCORE_W(16)) bus ();

    game_tick_sequencer #(
        .SPEED_STEP_TICKS(STEP),
        .MAX_LEVEL(MAXL),
        .SCORE_W(16),
        .LOCKOUT_TICKS(LOCK)
    ) dut (
        .device_clock(device_clock),
        .rst(rst),
        .clk_20Hz(clk_20Hz),
        .clk_500Hz(clk_500Hz),
        .btn_jump(btn_jump),
        .bus(bus)
    );

    always #5 device_clock = ~device_clock;

    int checks = 0;
    int errors = 0;

    // model: state 0 IDLE / 1 RUN / 2 OVER; level derived from successful ticks since the last start
    int m_state, m_score, m_good, m_lock;
    bit m_jump, m_prev;

    function automatic int m_level();
        return (m_good / STEP > MAXL) ? MAXL : m_good / STEP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge device_clock);
        #1;
    endtask

    task automatic strobes(input string tag, input logic [2:0] e);
        chk(tag, {29'd0, bus.upd_obstacle, bus.upd_dino, bus.chk_collide}, {29'd0, e});
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, {30'd0, bus.game_state}, m_state);
        chk({tag, ".score"}, {16'd0, bus.score}, m_score);
        chk({tag, ".level"}, {29'd0, bus.speed_level}, m_level());
        chk({tag, ".jump"}, {31'd0, bus.jump_req}, {31'd0, m_jump});
        strobes({tag, ".strobes"}, 3'b000);
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_good = 0; m_lock = 0; m_jump = 0; m_prev = 0;
    endtask

    task automatic model_start();
        m_state = 1; m_score = 0; m_good = 0; m_jump = 0;
    endtask

    task automatic scan(input bit b);
        btn_jump = b;
        clk_500Hz = 1'b1;
        cyc(3);
        if (b && !m_prev) begin
            if (m_state == 0) model_start();
            else if (m_state == 1) m_jump = 1;
            else if (m_lock >= LOCK) model_start();
        end
        m_prev = b;
        clk_500Hz = 1'b0;
        cyc(3);
    endtask

    task automatic press(input string tag);
        scan(1'b1);
        check_all(tag);
        scan(1'b0);
    endtask

    task automatic tick(input string tag, input bit col);
        logic [2:0] on;
        bit run;
        run = (m_state == 1);
        on = run ? 3'b111 : 3'b000;
        clk_20Hz = 1'b1;
        bus.collision = 1'($urandom);
        cyc(2);
        strobes({tag, ".pre"}, 3'b000);
        bus.collision = 1'($urandom);
        cyc(1);
        strobes({tag, ".obst"}, 3'b100 & on);
        bus.collision = 1'($urandom);
        cyc(1);
        strobes({tag, ".dino"}, 3'b010 & on);
        bus.collision = 1'($urandom);
        cyc(1);
        strobes({tag, ".coll"}, 3'b001 & on);
        cyc(1);
        strobes({tag, ".t3"}, 3'b000);
        bus.collision = col;
        cyc(1);
        bus.collision = 1'b0;
        clk_20Hz = 1'b0;
        if (run) begin
            m_jump = 0;
            if (col) begin
                m_state = 2;
                m_lock = 0;
            end else begin
                m_score = (m_score == 65535) ? m_score : m_score + 1;
                m_good++;
            end
        end else if (m_state == 2) begin
            m_lock = (m_lock + 1 > LOCK) ? LOCK : m_lock + 1;
        end
        cyc(3);
        check_all(tag);
    endtask

    int r;

    initial begin
        model_reset();
        bus.collision = 1'b0;
        // reset held with random inputs
        for (int i = 0; i < 20; i++) begin
            clk_20Hz = 1'($urandom);
            clk_500Hz = 1'($urandom);
            btn_jump = 1'($urandom);
            bus.collision = 1'($urandom);
            cyc(1);
            check_all("rst_hold");
        end
        clk_20Hz = 1'b0; clk_500Hz = 1'b0; btn_jump = 1'b0; bus.collision = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(100);
        check_all("rst_idle");

        // start and first sequence
        press("start");
        chk("start_state", {30'd0, bus.game_state}, 32'd1);
        chk("start_jump", {31'd0, bus.jump_req}, 32'd0);
        tick("first_tick", 1'b0);
        chk("first_score", {16'd0, bus.score}, 32'd1);

        // jump set, consumed by a tick, then a press landing on the upd_dino cycle
        press("jump_set");
        chk("jump_set_lit", {31'd0, bus.jump_req}, 32'd1);
        tick("jump_consume", 1'b0);
        chk("jump_consumed", {31'd0, bus.jump_req}, 32'd0);
        press("jump_again");
        clk_20Hz = 1'b1;
        cyc(2);
        btn_jump = 1'b1;
        clk_500Hz = 1'b1;
        cyc(2);
        strobes("race.dino", 3'b010);
        chk("race.jump_before", {31'd0, bus.jump_req}, 32'd1);
        cyc(1);
        strobes("race.coll", 3'b001);
        chk("race.jump_kept", {31'd0, bus.jump_req}, 32'd1);
        clk_500Hz = 1'b0;
        btn_jump = 1'b0;
        m_prev = 1;
        cyc(2);
        clk_20Hz = 1'b0;
        m_score++;
        m_good++;
        cyc(3);
        check_all("race_end");
        scan(1'b0);

        // game over and lockout
        tick("over", 1'b1);
        chk("over_state", {30'd0, bus.game_state}, 32'd2);
        for (int i = 0; i < 3; i++) tick("lock_a", 1'b0);
        press("early_press");
        chk("early_state", {30'd0, bus.game_state}, 32'd2);
        for (int i = 0; i < 7; i++) tick("lock_b", 1'b0);
        press("restart");
        chk("restart_state", {30'd0, bus.game_state}, 32'd1);
        chk("restart_score", {16'd0, bus.score}, 32'd0);
        chk("restart_level", {29'd0, bus.speed_level}, 32'd0);

        // speed levels with saturation
        for (int i = 1; i <= 12; i++) begin
            tick("speed", 1'b0);
            if (i == 4) chk("speed_l1", {29'd0, bus.speed_level}, 32'd1);
            if (i == 8) chk("speed_l2", {29'd0, bus.speed_level}, 32'd2);
        end
        chk("speed_sat", {29'd0, bus.speed_level}, 32'd2);
        chk("speed_score", {16'd0, bus.score}, 32'd12);

        // reset asserted at T+1
        clk_20Hz = 1'b1;
        cyc(4);
        strobes("mid.dino", 3'b010);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        clk_20Hz = 1'b0;
        cyc(3);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check_all("mid_after");
        end

        // held button gives one press
        for (int i = 0; i < 50; i++) scan(1'b1);
        check_all("held");
        chk("held_state", {30'd0, bus.game_state}, 32'd1);
        chk("held_jump", {31'd0, bus.jump_req}, 32'd0);
        scan(1'b0);

        // randomized play against the model
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) press("rnd_press");
            else tick("rnd_tick", $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
